// File: rtl/rand_sched_pkg.sv
// Shared types and constants for the LFSR sequencer / round-robin arbiter.
package rand_sched_pkg;

  localparam int unsigned SEED_CYCLES = 2;
  localparam int unsigned RNG_W       = 16;
  localparam int unsigned SEED_W      = 63;

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    WARM  = 2'd1,
    SERVE = 2'd2
  } state_t;

endpackage

// File: rtl/rand_sched_rr_pick.sv
// Combinational round-robin picker: the first set req at or after ptr wins.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  int unsigned pos;
  logic        found;

  // Scan requesters in rotated order starting from the pointer
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      pos = (32'(ptr) + off) % N_REQ;
      if (!found && req[IDX_W'(pos)]) begin
        found               = 1'b1;
        grant[IDX_W'(pos)]  = 1'b1;
        idx                 = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/rand_sched.sv
// Seeds the random generator, discards warm-up words, then hands each
// generated word to at most one of N_REQ requesters in round-robin order.
// Optional warm-up phase: define RAND_SCHED_WARMUP_EN to include WARM.
module rand_sched
  import rand_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WARMUP = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reseed_req,
  input  logic [SEED_W-1:0] seed_in,
  output logic              rng_reset,
  output logic [SEED_W-1:0] rng_seed,
  input  logic [RNG_W-1:0]  rng_data,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [RNG_W-1:0]  rand_data,
  output logic              busy
);

  localparam int unsigned IDX_W      = $clog2(N_REQ);
  localparam int unsigned SEED_CNT_W = $clog2(SEED_CYCLES);

  if (N_REQ < 2 || N_REQ > 16 || WARMUP < 1) begin : g_bad_param
    $error("rand_sched: N_REQ must be 2..16 and WARMUP >= 1");
  end

  state_t                state_q, state_d;
  logic [SEED_CNT_W-1:0] seed_cnt_q, seed_cnt_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]      gnt_d;
  logic [RNG_W-1:0]      rand_d;
  logic [SEED_W-1:0]     seed_d;
  logic                  busy_d, rng_reset_d;
  logic [N_REQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]      pick_idx;

`ifdef RAND_SCHED_WARMUP_EN
  localparam int unsigned WARM_W = $clog2(WARMUP + 1);
  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_gnt),
    .idx   (pick_idx)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= SEED;
      seed_cnt_q <= '0;
      ptr_q      <= '0;
      gnt        <= '0;
      rand_data  <= '0;
      rng_seed   <= seed_in;
      busy       <= 1'b1;
      rng_reset  <= 1'b0;
`ifdef RAND_SCHED_WARMUP_EN
      warm_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      seed_cnt_q <= seed_cnt_d;
      ptr_q      <= ptr_d;
      gnt        <= gnt_d;
      rand_data  <= rand_d;
      rng_seed   <= seed_d;
      busy       <= busy_d;
      rng_reset  <= rng_reset_d;
`ifdef RAND_SCHED_WARMUP_EN
      warm_cnt_q <= warm_cnt_d;
`endif
    end
  end

  // Next state, arbitration and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    seed_cnt_d = seed_cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    rand_d     = '0;
    seed_d     = rng_seed;
`ifdef RAND_SCHED_WARMUP_EN
    warm_cnt_d = warm_cnt_q;
`endif

    case (state_q)
      SEED: begin
`ifdef RAND_SCHED_WARMUP_EN
        warm_cnt_d = '0;
`endif
        if (seed_cnt_q == SEED_CNT_W'(SEED_CYCLES - 1)) begin
          seed_cnt_d = '0;
`ifdef RAND_SCHED_WARMUP_EN
          state_d    = WARM;
`else
          state_d    = SERVE;
`endif
        end else begin
          seed_cnt_d = seed_cnt_q + SEED_CNT_W'(1);
        end
      end
`ifdef RAND_SCHED_WARMUP_EN
      WARM: begin
        if (warm_cnt_q == WARM_W'(WARMUP - 1)) begin
          state_d = SERVE;
        end else begin
          warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
      end
`endif
      SERVE: begin
        if (|req) begin
          gnt_d  = pick_gnt;
          rand_d = rng_data;
          ptr_d  = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      default: state_d = SEED;
    endcase

    // A reseed overrides any grant decision taken this cycle
    if (reseed_req) begin
      state_d    = SEED;
      seed_cnt_d = '0;
      gnt_d      = '0;
      rand_d     = '0;
      ptr_d      = ptr_q;
      seed_d     = seed_in;
`ifdef RAND_SCHED_WARMUP_EN
      warm_cnt_d = '0;
`endif
    end

    rng_reset_d = (state_d != SEED);
    busy_d      = (state_d != SERVE);
  end

endmodule

// File: tb/tb_rand_sched.sv
// Directed bench for rand_sched with a behavioural 63-bit LFSR generator.
// Honours RAND_SCHED_WARMUP_EN the same way as the design.
module tb_rand_sched;
  import rand_sched_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 64;
`ifdef RAND_SCHED_WARMUP_EN
  localparam int unsigned W_EFF    = W;
  localparam int unsigned PULSE_AT = 12;
`else
  localparam int unsigned W_EFF    = 0;
  localparam int unsigned PULSE_AT = 1;
`endif
  localparam int unsigned BUSY_CYC = 2 + W_EFF;

  localparam logic [62:0] S1 = 63'h1;
  localparam logic [62:0] S2 = 63'h1234_5678_9ABC_DEF0;
  localparam logic [62:0] S3 = 63'h0BAD_F00D_CAFE_0123;

  logic              clk;
  logic              reset;
  logic              reseed_req;
  logic [62:0]       seed_in;
  logic              rng_reset;
  logic [62:0]       rng_seed;
  logic [15:0]       rng_data;
  logic [N-1:0]      req;
  logic [N-1:0]      gnt;
  logic [15:0]       rand_data;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [62:0] gen_q = '0;
  logic [62:0] mdl;
  logic [15:0] ref_w [0:5];
  logic [3:0]  rr_exp [0:4];
  int nb, nr, ng;

  rand_sched #(.N_REQ(N), .WARMUP(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .reseed_req (reseed_req),
    .seed_in    (seed_in),
    .rng_reset  (rng_reset),
    .rng_seed   (rng_seed),
    .rng_data   (rng_data),
    .req        (req),
    .gnt        (gnt),
    .rand_data  (rand_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 63-bit Fibonacci LFSR (x^63 + x^62 + 1), advanced 16 bits per clock
  function automatic logic [62:0] lfsr16(input logic [62:0] s);
    logic [62:0] t;
    t = s;
    for (int i = 0; i < 16; i++) t = {t[61:0], t[62] ^ t[61]};
    return t;
  endfunction

  // Generator stand-in: loads the seed while rng_reset is low
  always @(posedge clk) begin
    if (!rng_reset) gen_q <= rng_seed;
    else            gen_q <= lfsr16(gen_q);
  end
  assign rng_data = gen_q[15:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy / rng_reset-low / stray-grant cycles from the current sample point
  task automatic measure_busy(output int b, output int r, output int g);
    b = 0; r = 0; g = 0;
    for (int k = 0; k < 400 && busy; k++) begin
      b++;
      if (!rng_reset) r++;
      if (gnt != '0)  g++;
      tick();
    end
  endtask

  function automatic logic [62:0] warm(input logic [62:0] s);
    logic [62:0] t;
    t = s;
    for (int i = 0; i < int'(W_EFF); i++) t = lfsr16(t);
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    reset = 1'b0; reseed_req = 1'b0; seed_in = S1; req = 4'hF;
    repeat (3) tick();

    // Reset state
    check("rst_gnt",       64'(gnt),       64'h0);
    check("rst_rand",      64'(rand_data), 64'h0);
    check("rst_busy",      64'(busy),      64'h1);
    check("rst_rng_reset", 64'(rng_reset), 64'h0);
    check("rst_seed",      64'(rng_seed),  64'(S1));

    // Release and sequence through seeding / warm-up
    reset = 1'b1;
    measure_busy(nb, nr, ng);
    check("busy_len",        64'(nb), 64'(BUSY_CYC));
    check("rng_reset_len",   64'(nr), 64'd2);
    check("gnt_while_busy",  64'(ng), 64'd0);
    check("gnt_at_busy_fall", 64'(gnt), 64'h0);

    // Round-robin over all requesters
    mdl = warm(S1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gnt",  64'(gnt),       64'(rr_exp[k]));
      check("rr_word", 64'(rand_data), 64'(mdl[15:0]));
      mdl = lfsr16(mdl);
    end

    // Single requester granted every cycle with consecutive words
    req = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("single_gnt",  64'(gnt),       64'h4);
      check("single_word", 64'(rand_data), 64'(mdl[15:0]));
      mdl = lfsr16(mdl);
    end

    // Reseed in SERVE with a request pending, twice with the same seed
    for (int pass = 0; pass < 2; pass++) begin
      seed_in = S2; reseed_req = 1'b1;
      tick();
      reseed_req = 1'b0;
      check("reseed_gnt",  64'(gnt),      64'h0);
      check("reseed_seed", 64'(rng_seed), 64'(S2));
      measure_busy(nb, nr, ng);
      check("reseed_busy_len", 64'(nb), 64'(BUSY_CYC));
      check("reseed_rst_len",  64'(nr), 64'd2);
      check("reseed_no_gnt",   64'(ng), 64'd0);
      mdl = warm(S2);
      for (int k = 0; k < 6; k++) begin
        tick();
        check("reseed_gnt2", 64'(gnt), 64'h4);
        if (pass == 0) begin
          ref_w[k] = mdl[15:0];
          check("reseed_word", 64'(rand_data), 64'(mdl[15:0]));
        end else begin
          check("repeat_word", 64'(rand_data), 64'(ref_w[k]));
        end
        mdl = lfsr16(mdl);
      end
    end

    // Reseed again while still seeding / warming up
    req = 4'hF; seed_in = S2; reseed_req = 1'b1;
    tick();
    reseed_req = 1'b0;
    ng = 0; nb = 0;
    for (int k = 0; k < int'(PULSE_AT); k++) begin
      tick();
      if (busy) nb++;
      if (gnt != '0) ng++;
    end
    check("warm_busy_pre", 64'(nb), 64'(PULSE_AT));
    check("warm_gnt_pre",  64'(ng), 64'd0);
    seed_in = S3; reseed_req = 1'b1;
    tick();
    reseed_req = 1'b0;
    check("warm_reseed_seed", 64'(rng_seed), 64'(S3));
    measure_busy(nb, nr, ng);
    check("warm_busy_len", 64'(nb), 64'(BUSY_CYC));
    check("warm_no_gnt",   64'(ng), 64'd0);
    mdl = warm(S3);
    tick();
    check("warm_first_gnt",  64'(gnt),       64'h8);
    check("warm_first_word", 64'(rand_data), 64'(mdl[15:0]));

    // Reset asserted while a grant is showing
    req = 4'b0100;
    tick();
    check("pre_rst_gnt", 64'(gnt), 64'h4);
    reset = 1'b0; req = 4'hF;
    tick();
    check("midrst_gnt",       64'(gnt),       64'h0);
    check("midrst_rand",      64'(rand_data), 64'h0);
    check("midrst_busy",      64'(busy),      64'h1);
    check("midrst_rng_reset", 64'(rng_reset), 64'h0);
    reset = 1'b1;
    measure_busy(nb, nr, ng);
    check("midrst_busy_len", 64'(nb), 64'(BUSY_CYC));
    mdl = warm(S3);
    tick();
    check("midrst_first_gnt",  64'(gnt),       64'h1);
    check("midrst_first_word", 64'(rand_data), 64'(mdl[15:0]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_sched.md
# rand_sched

Sequencer and round-robin arbiter for the 16-bit parallel LFSR random source in the HPP automaton datapath. It seeds the generator by driving its active-low load/reset and seed bus. It discards a warm-up run of words, then shares the free-running random stream among N_REQ consumers (collision-rule cell updaters). Each generated word goes to at most one consumer.

## Interface
- N_REQ, 4, number of requesters, 2..16
- WARMUP, 64, generator words discarded after each seeding, ≥1
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- reseed_req  in  1  single-cycle pulse: reload the generator from seed_in
- seed_in  in  63  seed value; sampled during reset and on reseed_req
- rng_reset  out  1  to generator reset input; low = generator loads rng_seed
- rng_seed  out  63  to generator seed input; holds the latched seed
- rng_data  in  16  generator output word; fresh every clock
- req  in  N_REQ  per-consumer request; level, held until granted
- gnt  out  N_REQ  one-hot grant pulse, one cycle
- rand_data  out  16  word for the granted consumer; valid only while gnt≠0
- busy  out  1  high while seeding or warming up; no grants while high

## Operation
- States: SEED → WARM → SERVE.
- SEED:
  - rng_reset=0 for exactly SEED_CYCLES=2 cycles.
  - Warm counter is cleared.
- WARM:
  - rng_reset=1.
  - Counter counts WARMUP cycles, then the block enters SERVE.
- SERVE:
  - rng_reset=1, busy=0.
  - Each cycle, if any req bit is set, one requester is granted.
- Arbitration:
  - Round-robin. Priority starts at the index after the last granted one, wrapping N_REQ-1 → 0.
  - The pointer resets to 0 (req[0] highest).
- Grant:
  - gnt[i] and rand_data are registered from req and rng_data sampled on the same edge.
  - A requester whose req stays high after its grant is re-arbitrated. With a single requester it is granted every cycle.
  - Requester handshake: drop req the cycle after gnt[i] if no further word is needed.
- The generator advances every cycle. Because at most one grant is issued per cycle, no word is delivered twice.
- Words produced while no req is set are discarded.
- reseed_req:
  - Accepted in any state. It latches seed_in into rng_seed and enters SEED.
  - In SERVE it pre-empts arbitration: no gnt from the next edge on. A gnt already registered this cycle is still valid.
  - During SEED or WARM it restarts SEED with the new seed.
  - If it coincides with a grant decision, reseed wins and no grant is issued.
- Reset (reset=0), held for any number of cycles:
  - state=SEED, rng_seed←seed_in each cycle.
  - gnt=0, rand_data=0, busy=1, rng_reset=0, pointer=0.
- Reset mid-operation aborts everything identically. No partial grant survives.

## Timing
- From reset release, or from the edge that samples reseed_req: rng_reset low for 2 edges, busy high for 2+WARMUP cycles.
- The first gnt appears one cycle after busy falls, provided req is already high.
- Grant latency: 1 cycle from req sampled high (in SERVE) to gnt.
- Maximum throughput: one grant per cycle.
- Worst-case wait with all requesters active: N_REQ cycles.
- rand_data equals rng_data at the edge where gnt is registered. It holds 0 when gnt=0.

## Configuration
- RAND_SCHED_WARMUP_EN
  - Defined: WARM state and counter are present, as above.
  - Undefined: SEED goes directly to SERVE. busy is high for exactly 2 cycles after reset or reseed. The WARMUP parameter is ignored and no counter is synthesised.

## Structure
- Package rand_sched_pkg:
  - state enum {SEED, WARM, SERVE}
  - SEED_CYCLES=2
  - RNG_W=16
  - SEED_W=63
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req, pointer. Outputs: one-hot grant, grant index.
  - The parent holds and updates the pointer register.

## Test plan
- Reset with seed_in=63'h1, all req high, WARMUP=64:
  - rng_reset low exactly 2 cycles; busy high 66 cycles.
  - Then gnt cycles through 0001, 0010, 0100, 1000, 0001, one per cycle.
- Only req[2] held high in SERVE:
  - gnt[2] every cycle.
  - rand_data matches the reference LFSR model word-for-word, with no repeats or skips.
- reseed_req pulse in SERVE with seed_in=63'h1234_5678_9ABC_DEF0 and req pending:
  - gnt=0 from the next edge; rng_seed updates; busy high 66 cycles.
  - The post-warm-up stream equals the model seeded with that value.
  - Reseeding again with the same value reproduces an identical sequence.
- reseed_req during WARM (cycle 10 of 64):
  - SEED restarts; busy stays high a further 66 cycles from the pulse; no gnt appears meanwhile.
- reset asserted during SERVE while gnt=0100:
  - Next edge: gnt=0, rand_data=0, busy=1, rng_reset=0, pointer=0.
  - After release, the first grant goes to req[0] when all req are high.
- Built without RAND_SCHED_WARMUP_EN:
  - busy high exactly 2 cycles after reset.
  - The first word granted equals the generator's first post-seed word.
